// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared constants and types for the 5-3-4-1 binary perceptron
// sequencer. Holds layer sizes, weight-store base indices and the FSM state
// enum used by nn_sequencer.
package nn_seq_pkg;

  // Layer sizes: network inputs, hidden layer 1, hidden layer 2, output.
  localparam int IN_SIZE = 5;
  localparam int L1_SIZE = 3;
  localparam int L2_SIZE = 4;
  localparam int L3_SIZE = 1;

  // Base index of each layer's weights in the flat weight store.
  localparam int L1_BASE     = 0;
  localparam int L2_BASE     = L1_BASE + IN_SIZE * L1_SIZE;
  localparam int L3_BASE     = L2_BASE + L1_SIZE * L2_SIZE;
  localparam int NUM_WEIGHTS = L3_BASE + L2_SIZE * L3_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    L1,
    L2,
    L3,
    DONE
  } state_t;

endpackage

// File: rtl/nn_mac.sv
// nn_mac: shared accumulator and threshold decision for the sequencer.
// One weight term is added per enabled cycle; the running sum restarts at a
// neuron's first term. decision is the combinational (acc + term) > 0 test
// the sequencer latches on a neuron's last term.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   accumulate this cycle
//   first    in   this term is the neuron's first (ignore old accumulator)
//   sel      in   selected input bit; term is the weight when 1, else 0
//   weight   in   signed weight, Width bits
//   decision out  (acc + term) > 0, signed
module nn_mac
  import nn_seq_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    first,
  input  logic                    sel,
  input  logic signed [Width-1:0] weight,
  output logic                    decision
);

  // Three guard bits cover the widest fan-in (5 terms) with no overflow.
  localparam int AccW = Width + 3;

  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] term;
  logic signed [AccW-1:0] sum;

  assign term = sel ? {{3{weight[Width-1]}}, weight} : '0;
  assign sum  = (first ? '0 : acc) + term;

  // Strictly positive: sign bit clear and not zero, so a sum of 0 gives 0.
  assign decision = !sum[AccW-1] && (sum != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: evaluates a 5-3-4-1 binary perceptron network one weight
// term per cycle on a single shared accumulator (nn_mac). Weights live in a
// 31-entry signed store laid out in evaluation order, so the compute-cycle
// count doubles as the weight read address.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (clears weights too)
//   start    in   request one evaluation (honoured in IDLE only)
//   in       in   5-bit network input, captured on an accepted start
//   wr_en    in   weight write strobe (honoured in IDLE and DONE only)
//   wr_addr  in   weight index 0..30; larger indices are dropped
//   wr_data  in   signed weight value, Width bits
//   busy     out  evaluation in progress
//   done     out  one-cycle pulse, out valid
//   out      out  network output bit, held until the next DONE
//
// Build option: define NN_SEQ_DBG_EN to expose the registered hidden-layer
// bits on l1_out (3 bits) and l2_out (4 bits).
module nn_sequencer
  import nn_seq_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              in,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic signed [Width-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    out
`ifdef NN_SEQ_DBG_EN
  ,
  output logic [2:0]              l1_out,
  output logic [3:0]              l2_out
`endif
);

  state_t state;
  state_t state_next;

  logic [4:0] count;
  logic [2:0] j;
  logic [1:0] n;
  logic [4:0] in_reg;
  logic [2:0] l1_bits;
  logic [3:0] l2_bits;
  logic       sel;
  logic       last;
  logic       decision;
  logic       wr_ok;

  logic signed [Width-1:0] weights [NUM_WEIGHTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, status outputs and the per-layer input-bit mux.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    sel        = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = L1;
      end
      L1: begin
        busy = 1'b1;
        sel  = in_reg[j];
        last = (j == 3'(IN_SIZE - 1));
        if (count == 5'(L2_BASE - 1)) state_next = L2;
      end
      L2: begin
        busy = 1'b1;
        sel  = l1_bits[j[1:0]];
        last = (j == 3'(L1_SIZE - 1));
        if (count == 5'(L3_BASE - 1)) state_next = L3;
      end
      L3: begin
        busy = 1'b1;
        sel  = l2_bits[j[1:0]];
        last = (j == 3'(L2_SIZE - 1));
        if (count == 5'(NUM_WEIGHTS - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // count walks the weight store; j is the input index inside the current
  // neuron and n the neuron index inside the current layer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      j      <= '0;
      n      <= '0;
      in_reg <= '0;
    end else if (state == IDLE && start) begin
      count  <= 5'(L1_BASE);
      j      <= '0;
      n      <= '0;
      in_reg <= in;
    end else if (busy) begin
      count <= count + 5'd1;
      if (last) begin
        j <= '0;
        n <= (state_next != state) ? 2'd0 : n + 2'd1;
      end else begin
        j <= j + 3'd1;
      end
    end
  end

  // Latch each neuron's decision on its last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      l1_bits <= '0;
      l2_bits <= '0;
      out     <= 1'b0;
    end else if (busy && last) begin
      case (state)
        L1:      l1_bits[n] <= decision;
        L2:      l2_bits[n] <= decision;
        L3:      out        <= decision;
        default: ;
      endcase
    end
  end

  assign wr_ok = wr_en && (state == IDLE || state == DONE) &&
                 (wr_addr <= 5'(NUM_WEIGHTS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        weights[i] <= '0;
      end
    end else if (wr_ok) begin
      weights[wr_addr] <= wr_data;
    end
  end

  nn_mac #(
    .Width(Width)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .first   (j == 3'd0),
    .sel     (sel),
    .weight  (weights[count]),
    .decision(decision)
  );

`ifdef NN_SEQ_DBG_EN
  assign l1_out = l1_bits;
  assign l2_out = l2_bits;
`else
  // Hidden-layer bits stay internal in the default build.
`endif

endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: self-checking bench for nn_sequencer. A behavioural
// network model (plain sums over the weight map) plus a cycle timeline
// predicts busy/done/out every cycle; directed scenarios add literal checks.
module tb_nn_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        nn_in;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic              busy;
  logic              done;
  logic              nn_out;
`ifdef NN_SEQ_DBG_EN
  logic [2:0]        l1_out;
  logic [3:0]        l2_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic chk_en = 1'b0;

  nn_sequencer #(
    .Width(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (nn_in),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done),
    .out    (nn_out)
`ifdef NN_SEQ_DBG_EN
    ,
    .l1_out (l1_out),
    .l2_out (l2_out)
`endif
  );

  always #5 clk = ~clk;

  // Network reference: returns {l1[2:0], l2[3:0], out}.
  function automatic logic [7:0] net_eval(input logic [4:0] x, input int w[31]);
    logic [2:0] h1;
    logic [3:0] h2;
    logic       o;
    int         s;
    for (int nn = 0; nn < 3; nn++) begin
      s = 0;
      for (int k = 0; k < 5; k++) if (x[k]) s += w[nn*5 + k];
      h1[nn] = (s > 0);
    end
    for (int nn = 0; nn < 4; nn++) begin
      s = 0;
      for (int k = 0; k < 3; k++) if (h1[k]) s += w[15 + nn*3 + k];
      h2[nn] = (s > 0);
    end
    s = 0;
    for (int k = 0; k < 4; k++) if (h2[k]) s += w[27 + k];
    o = (s > 0);
    return {h1, h2, o};
  endfunction

  // Timeline: phase -1 idle, 0..30 compute cycles, 31 the done cycle.
  int         m_w[31];
  int         phase = -1;
  logic [4:0] m_in;
  logic [7:0] pend;
  logic       m_out;
  logic [2:0] m_l1;
  logic [3:0] m_l2;

  always @(posedge clk) begin
    if (rst) begin
      phase <= -1;
      m_out <= 1'b0;
      m_l1  <= '0;
      m_l2  <= '0;
      for (int i = 0; i < 31; i++) m_w[i] <= 0;
    end else begin
      if ((phase == -1 || phase == 31) && wr_en && wr_addr <= 5'd30)
        m_w[wr_addr] <= int'(wr_data);
      if (phase == -1) begin
        if (start) begin
          phase <= 0;
          m_in  <= nn_in;
        end
      end else if (phase == 31) begin
        phase <= -1;
      end else begin
        phase <= phase + 1;
        if (phase == 0)  pend  <= net_eval(m_in, m_w);
        if (phase == 14) m_l1  <= pend[7:5];
        if (phase == 26) m_l2  <= pend[4:1];
        if (phase == 30) m_out <= pend[0];
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", int'(busy), int'(phase >= 0 && phase <= 30));
      checkOutput("done", int'(done), int'(phase == 31));
      checkOutput("out", int'(nn_out), int'(m_out));
`ifdef NN_SEQ_DBG_EN
      checkOutput("l1_out", int'(l1_out), int'(m_l1));
      checkOutput("l2_out", int'(l2_out), int'(m_l2));
`endif
    end
  end

  task automatic applyStimulus(input logic s, input logic [4:0] x, input logic we,
                               input logic [4:0] a, input int d);
    @(negedge clk);
    start   = s;
    nn_in   = x;
    wr_en   = we;
    wr_addr = a;
    wr_data = 8'(d);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start one evaluation (optionally with a same-cycle weight write) and
  // report done latency from the start edge, busy cycles and the result.
  task automatic runEval(input logic [4:0] x, input logic we, input logic [4:0] a,
                         input int d, output int lat, output int bc, output int res);
    lat = 0;
    bc  = 0;
    res = -1;
    applyStimulus(1'b1, x, we, a, d);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        lat = c;
        res = int'(nn_out);
        break;
      end
    end
    applyStimulus(1'b0, x, 1'b0, 5'd0, 0);
  endtask

  int wb[31] = '{10, -10, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 0, 0, 0,
                 1, 1, 1,  1, 1, 1,  1, 1, 1,  1, 1, 1,  1, 1, 1, 1};
  int wc[31] = '{127, 127, 127, 127, 127,  -128, -128, -128, -128, -128,
                 127, 127, 127, 127, -128,
                 127, -128, -128,  1, 0, 0,  127, 127, 127,  -128, -128, -128,
                 127, -128, 127, 127};

  initial begin
    int lat, bc, res, nd, dout;
    int dt[3];
    int dv[3];

    rst = 1'b1;
    start = 1'b0;
    nn_in = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_out", int'(nn_out), 0);

    // All weights zero: timing and a zero result.
    runEval(5'b11111, 1'b0, 5'd0, 0, lat, bc, res);
    checkOutput("zero_latency", lat, 32);
    checkOutput("zero_busy_cycles", bc, 31);
    checkOutput("zero_out", res, 0);

    // Exact-zero sum in L1 neuron 0; everything else positive.
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 5'd0, 1'b1, 5'(i), wb[i]);
    runEval(5'b00011, 1'b0, 5'd0, 0, lat, bc, res);
    checkOutput("net_b_out", res, 1);
`ifdef NN_SEQ_DBG_EN
    checkOutput("net_b_l1", int'(l1_out), 6);
    checkOutput("net_b_l2", int'(l2_out), 15);
`endif

    // Write during L1 is dropped; start during L2 is ignored.
    applyStimulus(1'b1, 5'b00011, 1'b0, 5'd0, 0);
    applyStimulus(1'b0, 5'b00011, 1'b1, 5'd27, -100);
    repeat (17) applyStimulus(1'b0, 5'b00011, 1'b0, 5'd0, 0);
    applyStimulus(1'b1, 5'b00011, 1'b0, 5'd0, 0);
    applyStimulus(1'b0, 5'b00011, 1'b0, 5'd0, 0);
    nd = 0;
    dout = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        dout = int'(nn_out);
      end
    end
    checkOutput("busy_write_single_done", nd, 1);
    checkOutput("busy_write_out", dout, 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd31, -50);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 0);
    runEval(5'b00011, 1'b0, 5'd0, 0, lat, bc, res);
    checkOutput("addr31_out", res, 1);

    // Reset at compute cycle 10 aborts and clears the store.
    applyStimulus(1'b1, 5'b00011, 1'b0, 5'd0, 0);
    repeat (10) applyStimulus(1'b0, 5'b00011, 1'b0, 5'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_out", int'(nn_out), 0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checkOutput("abort_no_done", nd, 0);
    runEval(5'b11111, 1'b0, 5'd0, 0, lat, bc, res);
    checkOutput("abort_weights_zero", res, 0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd15, 1);
    runEval(5'b00001, 1'b1, 5'd27, 1, lat, bc, res);
    checkOutput("same_cycle_write_latency", lat, 32);
    checkOutput("same_cycle_write_out", res, 1);

    // Start held high: back-to-back runs, input change mid-run.
    applyStimulus(1'b1, 5'b00001, 1'b0, 5'd0, 0);
    nd = 0;
    dt = '{0, 0, 0};
    dv = '{-1, -1, -1};
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      if (c == 10) nn_in = 5'b00000;
      if (done) begin
        if (nd < 3) begin
          dt[nd] = c;
          dv[nd] = int'(nn_out);
        end
        nd++;
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", nd, 3);
    checkOutput("held_first_done", dt[0], 32);
    checkOutput("held_period_1", dt[1] - dt[0], 33);
    checkOutput("held_period_2", dt[2] - dt[1], 33);
    checkOutput("held_run1_out", dv[0], 1);
    checkOutput("held_run2_out", dv[1], 0);

    // Extreme weights: +127 x5, -128 x5, and sums landing on -1.
    doReset();
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 5'd0, 1'b1, 5'(i), wc[i]);
    runEval(5'b11111, 1'b0, 5'd0, 0, lat, bc, res);
    checkOutput("extreme_latency", lat, 32);
    checkOutput("extreme_out", res, 0);
`ifdef NN_SEQ_DBG_EN
    checkOutput("extreme_l1", int'(l1_out), 5);
    checkOutput("extreme_l2", int'(l2_out), 6);
`endif
    repeat (3) applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 Parameter: Width, 8, signed two's-complement weight width in bits.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  request one 5-3-4-1 network evaluation.
REQ-005 Port: in  in  5  binary network input, captured on an accepted start.
REQ-006 Port: wr_en  in  1  weight-write strobe.
REQ-007 Port: wr_addr  in  5  weight index, 0..30.
REQ-008 Port: wr_data  in  Width  signed weight value.
REQ-009 Port: busy  out  1  evaluation in progress.
REQ-010 Port: done  out  1  one-cycle pulse; result valid.
REQ-011 Port: out  out  1  network output bit.

Function
REQ-012 The block SHALL evaluate the 5-3-4-1 binary perceptron network on one shared accumulator, one weight term per cycle.
REQ-013 Weight map SHALL be: L1 neuron n (0..2), input j (0..4) -> index n*5+j. L2 neuron n (0..3), input j (0..2) -> 15+n*3+j. L3 input j (0..3) -> 27+j.
REQ-014 Evaluation order SHALL equal index order 0..30, so the weight read address equals the compute-cycle count.
REQ-015 Term k SHALL be the weight if the selected input bit is 1, else 0. Inputs are: L1 = captured in. L2 = L1 result bits. L3 = L2 result bits.
REQ-016 Accumulator SHALL be signed, Width+3 bits, and cleared at each neuron's first term. No overflow is possible.
REQ-017 On a neuron's last term, its bit SHALL be written as (acc + term) > 0, signed. A sum of exactly 0 SHALL give 0.
REQ-018 FSM states SHALL be IDLE, L1, L2, L3, DONE. Transitions:
- IDLE -> L1 on start.
- L1 -> L2 after index 14.
- L2 -> L3 after index 26.
- L3 -> DONE after index 30.
- DONE -> IDLE unconditionally.
REQ-019 Timing: start sampled high in IDLE at edge k SHALL give 31 compute cycles after edge k, then done=1 and out valid in the cycle after edge k+31.
REQ-020 busy SHALL be 1 in L1, L2 and L3, and 0 in IDLE and DONE.
REQ-021 out SHALL hold its value from DONE until the next DONE.
REQ-022 start SHALL be ignored outside IDLE, including in DONE.
REQ-023 Weight writes SHALL be accepted only in IDLE and DONE.
REQ-024 Weight writes while busy=1 SHALL be dropped silently.
REQ-025 A write with wr_addr > 30 SHALL be dropped.
REQ-026 start and wr_en in the same IDLE cycle SHALL both be accepted. The written weight SHALL be used by that evaluation.
REQ-027 in SHALL be captured only on an accepted start. Changes to in during an evaluation SHALL have no effect.

Reset
REQ-028 rst SHALL force:
- state = IDLE
- busy = 0, done = 0, out = 0
- accumulator, counters, L1/L2 result bits = 0
- all 31 weights = 0
REQ-029 rst asserted mid-evaluation SHALL abort the evaluation with no done pulse. start and wr_en SHALL be ignored in any cycle with rst=1.

Configuration
REQ-030 Macro NN_SEQ_DBG_EN defined SHALL add output ports l1_out (3 bits) and l2_out (4 bits). These show the registered hidden-layer bits, with reset value 0.
REQ-031 Without NN_SEQ_DBG_EN, those ports SHALL be absent. Function and timing SHALL be identical in both builds.

Structure
REQ-032 Package nn_seq_pkg SHALL hold:
- layer sizes (5, 3, 4, 1)
- base indices 0, 15, 27
- NUM_WEIGHTS = 31
- the FSM state enum
REQ-033 Sub-module nn_mac SHALL hold the accumulator and the threshold decision. nn_sequencer SHALL own the FSM, counters, weight store and input muxing.

Verification
REQ-034 All weights 0, in=5'b11111, start -> done exactly 32 cycles after the start edge, out=0, busy high for 31 cycles.
REQ-035 Weights set so that:
- L1 neuron 0 idx0 = +10 and idx1 = -10, other L1 weights 0 (sum 0 -> bit 0).
- L1 neurons 1 and 2 idx0 = +1.
- L2 weights all +1.
- L3 weights all +1.
Apply in=5'b00011 -> out=1. With NN_SEQ_DBG_EN: l1_out=3'b110, l2_out=4'b1111.
REQ-036 Weights at -128 and +127 extremes, in=5'b11111, 5 terms of +127 -> no overflow (635 > 0). 5 terms of -128 -> correct negative sum. Check each decision bit.
REQ-037 wr_en to idx 27 during L1 -> weight unchanged. Write to wr_addr 31 in IDLE -> store unchanged. Start during L2 -> ignored, a single done only.
REQ-038 rst pulsed at compute cycle 10 -> no done, busy=0 and out=0 next cycle, weights read back as zero. A fresh start then completes normally.
REQ-039 start held high continuously -> done every 33 cycles. Changing in mid-run does not affect that run's out.
